// File: rtl/adc_sample_timer.sv
// -----------------------------------------------------------------------------
// adc_sample_timer
//
// Periodic ADC sampler. A 16-bit period counter produces a tick every
// max(sample_div,2) refclk cycles while run (enable & pll_locked) is high.
// Each accepted tick runs one conversion frame:
//   IDLE -> CONV (2 cycles, convst high) -> WAIT (CONV_CYCLES cycles)
//        -> SHIFT (2*DATA_W cycles, cs_n low, sclk = refclk/2)
//        -> DONE (1 cycle, sample_valid) -> IDLE
// A tick that arrives while a frame is in progress is dropped and sets the
// sticky overrun flag. Dropping run aborts a frame back to IDLE.
//
// Ports
//   refclk        in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   pll_locked    in   PLL lock, already synchronous to refclk
//   enable        in   run sampling when high
//   sample_div    in   sample period in refclk cycles (0/1 behave as 2)
//   adc_sdo       in   ADC serial data, MSB first
//   adc_convst    out  conversion start strobe
//   adc_cs_n      out  ADC chip select, active low
//   adc_sclk      out  serial clock
//   sample_data   out  last completed sample
//   sample_valid  out  one-cycle pulse when sample_data updates
//   overrun       out  sticky dropped-tick flag
//   o_dbg_state   out  current FSM state (IDLE=0 CONV=1 WAIT=2 SHIFT=3 DONE=4)
// -----------------------------------------------------------------------------
module adc_sample_timer #(
  parameter int DATA_W      = 16,
  parameter int CONV_CYCLES = 20
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              enable,
  input  logic [15:0]       sample_div,
  input  logic              adc_sdo,
  output logic              adc_convst,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              overrun,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CONV  = 3'd1,
    S_WAIT  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Last value of the per-state step counter in each timed state.
  localparam logic [7:0] CONV_LAST  = 8'd1;
  localparam logic [7:0] WAIT_LAST  = 8'(CONV_CYCLES - 1);
  localparam logic [7:0] SHIFT_LAST = 8'(2 * DATA_W - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [7:0]          r_step;
  logic [15:0]         r_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_sample_data;
  logic                r_overrun;

  logic                w_run;
  logic [15:0]         w_period_last;
  logic                w_tick;
  logic                w_sclk;

  assign w_run         = enable & pll_locked;
  // P = max(sample_div, 2); compare against P-1.
  assign w_period_last = (sample_div < 16'd2) ? 16'd1 : (sample_div - 16'd1);
  // Equality compare only: a counter already past a newly lowered P-1 runs
  // on to 0xFFFF and wraps to 0 by plain overflow.
  assign w_tick        = w_run && (r_cnt == w_period_last);
  // sclk is low in the first SHIFT cycle and toggles every cycle after.
  assign w_sclk        = (r_state == S_SHIFT) && r_step[0];

  // Period counter
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_cnt <= 16'd0;
    end else if (!w_run || w_tick) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // FSM state register and datapath registers
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_step        <= 8'd0;
      r_shift       <= '0;
      r_sample_data <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_step  <= (w_state_next != r_state) ? 8'd0 : (r_step + 8'd1);
      // Capture on the edge ending each sclk-high cycle.
      if (w_sclk) begin
        r_shift <= {r_shift[DATA_W-2:0], adc_sdo};
      end
      // Load on entry to DONE so the new word is visible with sample_valid.
      if (r_state == S_SHIFT && w_state_next == S_DONE) begin
        r_sample_data <= {r_shift[DATA_W-2:0], adc_sdo};
      end
      if (w_tick && r_state != S_IDLE) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_tick)                 w_state_next = S_CONV;
      S_CONV:  if (r_step == CONV_LAST)    w_state_next = S_WAIT;
      S_WAIT:  if (r_step == WAIT_LAST)    w_state_next = S_SHIFT;
      S_SHIFT: if (r_step == SHIFT_LAST)   w_state_next = S_DONE;
      S_DONE:                              w_state_next = S_IDLE;
      default:                             w_state_next = S_IDLE;
    endcase
    // Losing run aborts any frame; outputs fall to idle levels next cycle.
    if (!w_run) begin
      w_state_next = S_IDLE;
    end
  end

  // Output logic
  always_comb begin
    adc_convst   = (r_state == S_CONV);
    adc_cs_n     = (r_state != S_SHIFT);
    adc_sclk     = w_sclk;
    sample_valid = (r_state == S_DONE);
    sample_data  = r_sample_data;
    overrun      = r_overrun;
    o_dbg_state  = r_state;
  end

endmodule

// File: tb/tb_adc_sample_timer.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_timer
//
// Reference model: frames are described by the cycle t0 of their accepted
// tick; every output is derived from the offset (cycle - t0). Ticks occur
// at run_start + k*P + P-1. Expected samples go into exp_q at the tick and a
// separate monitor pops them when sample_valid appears.
// Handshake: sample_valid is a one-cycle pulse with no back-pressure; the
// word on sample_data in that cycle is the sample.
// -----------------------------------------------------------------------------
module tb_adc_sample_timer;

  localparam int D   = 16;
  localparam int C   = 20;
  localparam int LAT = 3 + C + 2 * D;

  // clock / reset
  logic refclk = 1'b0;
  always #5 refclk = ~refclk;

  logic          rst = 1'b1;
  logic          pll_locked = 1'b1;
  logic          enable = 1'b0;
  logic [15:0]   sample_div = 16'd100;
  logic          adc_sdo = 1'b0;
  logic          adc_convst, adc_cs_n, adc_sclk, sample_valid, overrun;
  logic [D-1:0]  sample_data;
  logic [2:0]    dbg_state;

  adc_sample_timer #(.DATA_W(D), .CONV_CYCLES(C)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .enable(enable),
    .sample_div(sample_div), .adc_sdo(adc_sdo), .adc_convst(adc_convst),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .sample_data(sample_data),
    .sample_valid(sample_valid), .overrun(overrun), .o_dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard queues
  logic [D-1:0] exp_q[$];
  int           exp_t_q[$];

  // reference model state
  bit           m_check_en = 0;
  bit           m_in_run = 0;
  int           m_run_start = 0;
  bit           m_busy = 0;
  int           m_t0 = 0;
  bit           m_ovr = 0;
  logic [D-1:0] m_sd = '0;
  logic [D-1:0] m_word = '0;
  bit           fixed_word = 0;

  always @(negedge refclk) begin
    int c, off, p;
    bit conv_e, shift_e, sclk_e, run, tick;
    c = cyc;
    conv_e = 0; shift_e = 0; sclk_e = 0;
    if (m_busy) begin
      off     = c - m_t0;
      conv_e  = (off <= 2);
      shift_e = (off >= 3 + C) && (off <= 2 + C + 2 * D);
      sclk_e  = shift_e && (((off - 3 - C) % 2) == 1);
      if (off == LAT) m_sd = m_word;
    end
    if (m_check_en) begin
      chk("convst",      adc_convst, conv_e);
      chk("cs_n",        adc_cs_n,   !shift_e);
      chk("sclk",        adc_sclk,   sclk_e);
      chk("overrun",     overrun,    m_ovr);
      chk("sample_data", sample_data, m_sd);
    end
    // events of this cycle shape the next one
    p = (sample_div < 2) ? 2 : int'(sample_div);
    if (rst) begin
      if (m_busy && c < m_t0 + LAT) begin void'(exp_q.pop_back()); void'(exp_t_q.pop_back()); end
      m_busy = 0; m_in_run = 0; m_ovr = 0; m_sd = '0; m_check_en = 1;
    end else begin
      run = enable && pll_locked;
      if (!run) begin
        if (m_busy && c < m_t0 + LAT) begin void'(exp_q.pop_back()); void'(exp_t_q.pop_back()); end
        m_busy = 0; m_in_run = 0;
      end else begin
        if (!m_in_run) begin m_in_run = 1; m_run_start = c; end
        tick = ((c - m_run_start) % p) == (p - 1);
        if (m_busy && c == m_t0 + LAT) begin
          if (tick) m_ovr = 1;
          m_busy = 0;
        end else if (tick && m_busy) begin
          m_ovr = 1;
        end else if (tick) begin
          m_busy = 1; m_t0 = c;
          m_word = fixed_word ? 16'hA5C3 : D'($urandom);
          exp_q.push_back(m_word);
          exp_t_q.push_back(c + LAT);
        end
      end
    end
  end

  // ADC serial driver: present the next bit while sclk is low
  int bit_idx = 0;
  always @(negedge refclk) begin
    if (adc_cs_n) bit_idx = 0;
    else if (!adc_sclk && bit_idx < D) begin
      adc_sdo = m_word[D - 1 - bit_idx];
      bit_idx++;
    end
  end

  // monitor: frame shape counting and scoreboard pop on sample_valid
  bit prev_cs_n = 1, prev_sclk = 0;
  int frame_rises = 0, frame_cs_low = 0;
  bit end_check = 0, end_done = 0;
  always @(negedge refclk) begin
    logic [D-1:0] e_data;
    int e_t;
    if (!adc_cs_n) begin
      if (prev_cs_n) begin frame_rises = 0; frame_cs_low = 0; end
      frame_cs_low++;
      if (adc_sclk && !prev_sclk) frame_rises++;
    end
    prev_cs_n = adc_cs_n;
    prev_sclk = adc_sclk;
    if (m_check_en && sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e_data = exp_q.pop_front();
        e_t    = exp_t_q.pop_front();
        chk("valid_data",  sample_data, e_data);
        chk("valid_cycle", cyc, e_t);
        chk("sclk_rises",  frame_rises, D);
        chk("cs_low_len",  frame_cs_low, 2 * D);
      end
    end
    if (end_check && !end_done) begin
      chk("pending_at_end", exp_q.size(), 0);
      end_done = 1;
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic run_off(input int n);
    enable = 1'b0;
    cycles(n);
  endtask

  initial begin
    int len, chunk;
    // reset
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // steady sampling with a fixed word, P = 100
    fixed_word = 1;
    sample_div = 16'd100;
    enable = 1'b1;
    cycles(460);
    run_off(3);
    fixed_word = 0;

    // P = 56: no overrun
    sample_div = 16'd56;
    enable = 1'b1;
    cycles(600);
    run_off(3);

    // P = 55: overrun, sample every 110 cycles
    sample_div = 16'd55;
    enable = 1'b1;
    cycles(400);
    run_off(3);

    rst = 1'b1; cycles(1); rst = 1'b0; cycles(2);

    // lock lost for one cycle mid-SHIFT, then relock
    sample_div = 16'd100;
    enable = 1'b1;
    cycles(99 + 40);
    pll_locked = 1'b0; cycles(1); pll_locked = 1'b1;
    cycles(300);
    run_off(3);

    // sample_div 0 and 1 behave as P = 2
    sample_div = 16'd0; enable = 1'b1; cycles(150); run_off(2);
    sample_div = 16'd1; enable = 1'b1; cycles(150); run_off(2);

    // reset mid-WAIT while overrun is set
    sample_div = 16'd100;
    enable = 1'b1;
    cycles(99 + 10);
    rst = 1'b1; cycles(1); rst = 1'b0;
    cycles(200);
    run_off(3);

    // randomized segments
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 4))
        0:       sample_div = 16'd0;
        1:       sample_div = 16'd1;
        default: sample_div = 16'($urandom_range(2, 150));
      endcase
      enable = 1'b1;
      len = $urandom_range(100, 600);
      while (len > 0) begin
        chunk = $urandom_range(1, 60);
        cycles(chunk);
        len -= chunk;
        if ($urandom_range(0, 9) == 0) begin
          pll_locked = 1'b0; cycles($urandom_range(1, 3)); pll_locked = 1'b1;
        end
        if ($urandom_range(0, 19) == 0) begin
          rst = 1'b1; cycles(1); rst = 1'b0;
        end
      end
      run_off($urandom_range(1, 4));
    end

    run_off(4);
    end_check = 1;
    for (int i = 0; i < 10 && !end_done; i++) cycles(1);
    if (!end_done) chk("end_check_timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sample_timer.md
ADC_SAMPLE_TIMER -- requirements
Module: adc_sample_timer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the ADC word width in bits (range 8..32).
REQ-002 The block SHALL have parameter CONV_CYCLES, default 20, meaning the refclk cycles of conversion wait after CONVST (range 1..255).
REQ-003 The block SHALL have port refclk  input  1  meaning the single clock, the PLL 32.768 MHz output; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port pll_locked  input  1  meaning the PLL lock indication, already synchronous to refclk.
REQ-006 The block SHALL have port enable  input  1  meaning run sampling when high.
REQ-007 The block SHALL have port sample_div  input  16  meaning the sample period in refclk cycles.
REQ-008 The block SHALL have port adc_sdo  input  1  meaning the ADC serial data, MSB first.
REQ-009 The block SHALL have port adc_convst  output  1  meaning the conversion start strobe.
REQ-010 The block SHALL have port adc_cs_n  output  1  meaning the ADC chip select, active low.
REQ-011 The block SHALL have port adc_sclk  output  1  meaning the serial clock, refclk/2.
REQ-012 The block SHALL have port sample_data  output  DATA_W  meaning the last completed sample.
REQ-013 The block SHALL have port sample_valid  output  1  meaning a one-cycle pulse when sample_data updates.
REQ-014 The block SHALL have port overrun  output  1  meaning a sticky flag for a dropped sample tick.

Function
REQ-015 Run condition: run = enable AND pll_locked, evaluated every cycle.
REQ-016 Period counter: 16-bit; counts 0..P-1 then wraps to 0 while run is high, where P = max(sample_div, 2).
REQ-017 The tick SHALL be asserted in the cycle the counter holds P-1.
REQ-018 While run is low, the counter SHALL be held at 0 and no tick SHALL be generated.
REQ-019 FSM states SHALL be IDLE, CONV, WAIT, SHIFT and DONE.
REQ-020 A tick in cycle T with state IDLE SHALL make state CONV in cycle T+1.
REQ-021 CONV SHALL last 2 cycles with adc_convst=1; adc_convst SHALL be 0 in all other states.
REQ-022 WAIT SHALL last CONV_CYCLES cycles.
REQ-023 SHIFT SHALL last 2*DATA_W cycles, with adc_cs_n=0 and adc_sclk=0 in its first cycle, toggling every cycle.
REQ-024 In SHIFT, adc_sdo SHALL be shifted in MSB first in each cycle where adc_sclk is 1, DATA_W bits in total.
REQ-025 Outside SHIFT, adc_cs_n SHALL be 1 and adc_sclk SHALL be 0.
REQ-026 DONE SHALL last 1 cycle: sample_data is loaded from the shift register and sample_valid=1 in that cycle; the next state is IDLE.
REQ-027 Latency from tick to sample_valid SHALL be 3+CONV_CYCLES+2*DATA_W cycles (55 at defaults); the minimum non-overrun P is that value plus 1 (56 at defaults).
REQ-028 A tick while state is not IDLE SHALL be dropped, set overrun=1, and leave the in-progress conversion unaffected.
REQ-029 overrun SHALL be cleared only by rst.
REQ-030 If run goes low in any non-IDLE state, the FSM SHALL return to IDLE on the next cycle, with outputs at idle levels in that cycle.
REQ-031 An abort per REQ-030 SHALL produce no sample_valid and leave sample_data unchanged.
REQ-032 A change to sample_div mid-period SHALL take effect at the next comparison; if the counter is at or above the new P-1, it SHALL wrap at 0xFFFF→0 naturally, with no special handling.

Reset
REQ-033 rst SHALL take priority over all other inputs in the same cycle.
REQ-034 On rst, the counter SHALL be 0 and the state IDLE.
REQ-035 On rst: adc_convst=0, adc_cs_n=1, adc_sclk=0, sample_data=0, sample_valid=0, overrun=0.
REQ-036 rst asserted mid-SHIFT SHALL discard the partial word.

Verification
REQ-037 Defaults, sample_div=100, run high, adc_sdo driven with 0xA5C3 MSB first on sclk rising -> sample_valid every 100 cycles, sample_data=0xA5C3, first valid 55 cycles after the first tick.
REQ-038 sample_div=56 -> no overrun for 10 periods; sample_div=55 -> overrun=1 after the second tick, sample_valid still every 110 cycles.
REQ-039 pll_locked dropped for 1 cycle mid-SHIFT -> next cycle IDLE, adc_cs_n=1, no sample_valid, sample_data holds the prior value; relock -> the first tick comes P cycles later.
REQ-040 sample_div=0 and sample_div=1 -> behave as P=2: tick every 2 cycles, overrun set.
REQ-041 rst pulsed mid-WAIT with overrun=1 -> all outputs at reset values the next cycle, overrun=0.
REQ-042 Count adc_sclk rising edges per frame -> exactly DATA_W, and adc_cs_n low for exactly 2*DATA_W cycles.
